muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sequencer_if.sv | 40 ++++
 rtl/flopenr.sv | 18 +
 rtl/muldiv_iter.sv | 43 ++++
 rtl/muldiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 6 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - op encodings presented on opE by the execute stage
//   - FSM state enum (also exported on the debug state port)
//   - quotient value committed to LO on divide-by-zero
package muldiv_pkg;

  localparam int MD_DEF_WIDTH = 32;
  localparam int MD_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  // Divide-by-zero quotient is all ones; sliced to the operand width at use.
  localparam logic [MD_MAX_WIDTH-1:0] MD_DIVZERO_Q = '1;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the execute/hazard logic and the muldiv sequencer.
//
// Handshake: startE is a one-cycle issue strobe from the execute stage and
// busy is the sequencer's not-ready. busy rises combinationally with startE
// and stays high until the cycle the result commits; the issuer must not
// raise startE again while the sequencer is out of IDLE. done is a one-cycle
// pulse in the first cycle the new hi/lo are visible; divzero pulses with it.
// hiwe/lowe (MTHI/MTLO) are accepted only while the sequencer is idle.
//
// Signals:
//   startE, opE, srcaE, srcbE : issue strobe, op select, rs/rt operands
//   hiwe, lowe, wdata         : MTHI/MTLO write enables and data
//   busy, done, divzero       : status toward the hazard unit / pipeline
//   hi, lo                    : architectural HI/LO registers
interface muldiv_sequencer_if #(
  parameter int WIDTH = muldiv_pkg::MD_DEF_WIDTH
);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             hiwe;
  logic             lowe;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output startE, opE, srcaE, srcbE, hiwe, lowe, wdata,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, hiwe, lowe, wdata,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset.
//   clk, reset : clock and synchronous reset (clears q)
//   i_en       : load enable
//   i_d / o_q  : data in / registered data out
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge clk) begin
    if (reset)     o_q <= '0;
    else if (i_en) o_q <= i_d;
  end
endmodule

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned multiply/divide datapath (combinational).
//   i_div     : 0 = shift-add multiply step, 1 = restoring divide step
//   i_acc     : multiply: {partial product hi, remaining multiplier bits}
//               divide:   lower half holds dividend bits / quotient bits
//   i_rem     : partial remainder (divide only)
//   i_mcand   : multiplicand magnitude
//   i_divisor : divisor magnitude
//   o_acc/o_rem : accumulator and remainder after this step
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH:0]     i_rem,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [WIDTH:0]     o_rem
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
            + {1'b0, (i_acc[0] ? i_mcand : {WIDTH{1'b0}})};
    // Divide: bring the next dividend bit (MSB first) into the remainder.
    w_shift = {i_rem, i_acc[WIDTH-1]};
    w_ge    = (w_shift >= {2'b00, i_divisor});
    // Only used when w_ge, where the true difference fits in WIDTH+1 bits.
    w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};

    o_acc = {w_sum, i_acc[WIDTH-1:1]};
    o_rem = i_rem;
    if (i_div) begin
      o_acc = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-2:0], w_ge};
      o_rem = w_ge ? w_diff : w_shift[WIDTH:0];
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit and owner of the HI/LO registers.
// Operands are reduced to magnitudes at issue, WIDTH unsigned iterations run
// in RUN, and FIX applies sign correction while committing HI/LO.
//   clk, reset  : clock, synchronous active-high reset
//   md (slave)  : issue/operand, MTHI/MTLO, status and HI/LO signals
//   o_dbg_state : current FSM state
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_DEF_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   md,
  output md_state_e           o_dbg_state
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_opa, r_opb, r_raw_a;
  logic               r_is_div, r_neg_res, r_neg_rem, r_dz;
  logic               r_done, r_divzero;

  logic               w_start, w_fix, w_busy, w_hi_en, w_lo_en;
  logic               w_is_div, w_signed, w_sa, w_sb;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_iter_acc, w_prod;
  logic [WIDTH:0]     w_iter_rem;
  logic [WIDTH-1:0]   w_quot, w_remv, w_fix_hi, w_fix_lo;
  logic [WIDTH-1:0]   w_hi_d, w_lo_d, w_hi_q, w_lo_q;

  // Issue decode: magnitudes for signed ops, raw values for unsigned ops.
  always_comb begin
    w_is_div = (md.opE == MD_DIV) || (md.opE == MD_DIVU);
    w_signed = (md.opE == MD_MULT) || (md.opE == MD_DIV);
    w_sa     = w_signed & md.srcaE[WIDTH-1];
    w_sb     = w_signed & md.srcbE[WIDTH-1];
    w_mag_a  = w_sa ? -md.srcaE : md.srcaE;
    w_mag_b  = w_sb ? -md.srcbE : md.srcbE;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (md.startE)     w_next = RUN;
      RUN:     if (r_cnt == '0)   w_next = FIX;
      FIX:                        w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // FSM: outputs. A start in IDLE takes priority over MTHI/MTLO.
  always_comb begin
    w_start = (r_state == IDLE) & md.startE;
    w_fix   = (r_state == FIX);
    w_busy  = ~reset & ((r_state != IDLE) | md.startE);
    w_hi_en = w_fix | ((r_state == IDLE) & md.hiwe & ~md.startE);
    w_lo_en = w_fix | ((r_state == IDLE) & md.lowe & ~md.startE);
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_div     (r_is_div),
    .i_acc     (r_acc),
    .i_rem     (r_rem),
    .i_mcand   (r_opa),
    .i_divisor (r_opb),
    .o_acc     (w_iter_acc),
    .o_rem     (w_iter_rem)
  );

  // Operand latch, iteration counter and accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_raw_a   <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= CW'(WIDTH - 1);
      // Multiply walks the multiplier bits; divide walks the dividend bits.
      r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      r_rem     <= '0;
      r_opa     <= w_mag_a;
      r_opb     <= w_mag_b;
      r_raw_a   <= md.srcaE;
      r_is_div  <= w_is_div;
      r_neg_res <= w_sa ^ w_sb;
      r_neg_rem <= w_sa;
      r_dz      <= w_is_div & (md.srcbE == '0);
    end else if (r_state == RUN) begin
      r_cnt     <= r_cnt - 1'b1;
      r_acc     <= w_iter_acc;
      r_rem     <= w_iter_rem;
    end
  end

  // Sign correction and commit values.
  always_comb begin
    w_prod = r_neg_res ? -r_acc : r_acc;
    w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_remv = r_neg_rem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    if (r_dz) begin
      w_fix_hi = r_raw_a;
      w_fix_lo = MD_DIVZERO_Q[WIDTH-1:0];
    end else if (r_is_div) begin
      w_fix_hi = w_remv;
      w_fix_lo = w_quot;
    end else begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end
    w_hi_d = w_fix ? w_fix_hi : md.wdata;
    w_lo_d = w_fix ? w_fix_lo : md.wdata;
  end

  flopenr #(.WIDTH(WIDTH)) u_hi (
    .clk(clk), .reset(reset), .i_en(w_hi_en), .i_d(w_hi_d), .o_q(w_hi_q)
  );
  flopenr #(.WIDTH(WIDTH)) u_lo (
    .clk(clk), .reset(reset), .i_en(w_lo_en), .i_d(w_lo_d), .o_q(w_lo_q)
  );

  // done/divzero are registered so they line up with the new HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= w_fix;
      r_divzero <= w_fix & r_dz;
    end
  end

  assign md.busy     = w_busy;
  assign md.done     = r_done;
  assign md.divzero  = r_divzero;
  assign md.hi       = w_hi_q;
  assign md.lo       = w_lo_q;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  md_state_e  dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];

  int           lat, bcyc, seen;
  logic [W-1:0] mid_hi, mid_lo;

  muldiv_sequencer_if #(.WIDTH(W)) md_if ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .md          (md_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // issuing while the unit is out of IDLE is a stimulus error
  always @(negedge clk) begin
    if (reset === 1'b0 && dbg_state !== IDLE) begin
      assert (md_if.startE !== 1'b1) else begin
        errors++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // compare hi then lo against the two oldest scoreboard entries
  task automatic chk_result(input string tag);
    logic [W-1:0] e_hi, e_lo;
    e_hi = exp_q.pop_front();
    e_lo = exp_q.pop_front();
    chk({tag, "_hi"}, md_if.hi, e_hi);
    chk({tag, "_lo"}, md_if.lo, e_lo);
  endtask

  // Issue one op and wait (bounded) for done. lat = edges from issue to done
  // visible, bcyc = cycles with busy high including the issue cycle,
  // mid_hi/mid_lo = HI/LO sampled 10 edges after issue.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic noise, input logic wr_start,
                        output int o_lat, output int o_bcyc,
                        output logic [W-1:0] o_mid_hi, output logic [W-1:0] o_mid_lo);
    md_if.opE    = op;
    md_if.srcaE  = a;
    md_if.srcbE  = b;
    md_if.startE = 1'b1;
    if (wr_start) begin
      md_if.hiwe  = 1'b1;
      md_if.lowe  = 1'b1;
      md_if.wdata = 32'h1111_1111;
    end
    #1;
    o_bcyc   = (md_if.busy === 1'b1) ? 1 : 0;
    o_lat    = 0;
    o_mid_hi = '0;
    o_mid_lo = '0;
    do begin
      @(posedge clk);
      #1;
      md_if.startE = 1'b0;
      md_if.hiwe   = noise;
      md_if.lowe   = noise;
      md_if.wdata  = 32'hDEAD_BEEF;
      o_lat++;
      if (o_lat == 10) begin
        o_mid_hi = md_if.hi;
        o_mid_lo = md_if.lo;
      end
      if (md_if.busy === 1'b1) o_bcyc++;
    end while (md_if.done !== 1'b1 && o_lat < 100);
    md_if.hiwe = 1'b0;
    md_if.lowe = 1'b0;
    #1;
  endtask

  initial begin
    md_if.startE = 1'b0;
    md_if.opE    = 2'b00;
    md_if.srcaE  = '0;
    md_if.srcbE  = '0;
    md_if.hiwe   = 1'b0;
    md_if.lowe   = 1'b0;
    md_if.wdata  = '0;

    // reset
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("rst_hi",      md_if.hi, 32'h0);
    chk("rst_lo",      md_if.lo, 32'h0);
    chk("rst_done",    32'(md_if.done), 32'h0);
    chk("rst_divzero", 32'(md_if.divzero), 32'h0);
    chk("rst_busy",    32'(md_if.busy), 32'h0);
    chk("rst_state",   32'(dbg_state), 32'(IDLE));

    // MULTU max*max, with latency and busy length
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'h0000_0001);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("multu_latency", 32'(lat), 32'd34);
    chk("multu_busy_cycles", 32'(bcyc), 32'd34);
    chk("multu_divzero", 32'(md_if.divzero), 32'h0);
    chk_result("multu_max");
    cyc();
    chk("done_one_cycle", 32'(md_if.done), 32'h0);
    chk("busy_after", 32'(md_if.busy), 32'h0);

    // signed multiplies
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFA);
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk_result("mult_m2x3");

    exp_q.push_back(32'h4000_0000); exp_q.push_back(32'h0000_0000);
    run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk_result("mult_minxmin");

    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFDD);
    run_op(MD_MULT, 32'h0000_0007, 32'hFFFF_FFFB, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk_result("mult_7xm5");

    // divides: lo = quotient, hi = remainder
    exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFFF_FFFD);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk_result("div_m7d2");

    exp_q.push_back(32'd2); exp_q.push_back(32'd14);
    run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("divu_latency", 32'(lat), 32'd34);
    chk_result("divu_100d7");

    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h8000_0000);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("div_ovf_divzero", 32'(md_if.divzero), 32'h0);
    chk_result("div_min_dm1");

    // divide by zero
    exp_q.push_back(32'h0000_1234); exp_q.push_back(32'hFFFF_FFFF);
    run_op(MD_DIVU, 32'h0000_1234, 32'h0, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("divz_latency", 32'(lat), 32'd34);
    chk("divz_flag", 32'(md_if.divzero), 32'h1);
    chk_result("divu_by0");
    cyc();
    chk("divz_pulse_end", 32'(md_if.divzero), 32'h0);

    exp_q.push_back(32'hFFFF_FFF9); exp_q.push_back(32'hFFFF_FFFF);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("divz_signed_flag", 32'(md_if.divzero), 32'h1);
    chk_result("div_m7by0");

    exp_q.push_back(32'h0000_0001); exp_q.push_back(32'hFFFF_FFFD);
    run_op(MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk_result("div_7dm2");

    // MTHI / MTLO in IDLE
    md_if.hiwe = 1'b1; md_if.wdata = 32'h0000_AAAA;
    cyc();
    md_if.hiwe = 1'b0;
    chk("mthi_hi", md_if.hi, 32'h0000_AAAA);
    chk("mthi_lo_kept", md_if.lo, 32'hFFFF_FFFD);
    md_if.lowe = 1'b1; md_if.wdata = 32'h0000_5555;
    cyc();
    md_if.lowe = 1'b0;
    chk("mtlo_lo", md_if.lo, 32'h0000_5555);
    chk("mtlo_hi_kept", md_if.hi, 32'h0000_AAAA);

    // MTHI/MTLO during RUN/FIX are ignored
    exp_q.push_back(32'h0000_0001); exp_q.push_back(32'h0000_0000);
    run_op(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("mt_run_mid_hi", mid_hi, 32'h0000_AAAA);
    chk("mt_run_mid_lo", mid_lo, 32'h0000_5555);
    chk_result("multu_noise");

    // start and MTHI/MTLO in the same cycle: writes dropped
    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'h0000_0006);
    run_op(MD_MULTU, 32'd2, 32'd3, 1'b0, 1'b1, lat, bcyc, mid_hi, mid_lo);
    chk("start_wr_mid_hi", mid_hi, 32'h0000_0001);
    chk("start_wr_mid_lo", mid_lo, 32'h0000_0000);
    chk_result("multu_start_wr");

    // reset in the middle of a DIVU
    md_if.hiwe = 1'b1; md_if.wdata = 32'h0000_0077;
    cyc();
    md_if.hiwe = 1'b0;
    chk("pre_rst_hi", md_if.hi, 32'h0000_0077);
    md_if.opE = MD_DIVU; md_if.srcaE = 32'hFFFF_FFFF; md_if.srcbE = 32'd3;
    md_if.startE = 1'b1;
    cyc();
    md_if.startE = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    #1;
    chk("rst_mid_busy_comb", 32'(md_if.busy), 32'h0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(md_if.busy), 32'h0);
    chk("rst_mid_hi", md_if.hi, 32'h0);
    chk("rst_mid_lo", md_if.lo, 32'h0);
    chk("rst_mid_done", 32'(md_if.done), 32'h0);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    seen = 0;
    repeat (40) begin
      cyc();
      if (md_if.done === 1'b1) seen++;
    end
    chk("rst_mid_no_done", 32'(seen), 32'h0);

    exp_q.push_back(32'h0000_0000); exp_q.push_back(32'd15);
    run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, lat, bcyc, mid_hi, mid_lo);
    chk("post_rst_latency", 32'(lat), 32'd34);
    chk_result("multu_3x5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
